// File: rtl/myproject_mul_acc_pipe_if.sv
// Sample/result bundle for myproject_mul_acc_pipe: clock enable, operand
// inputs with their valid tag, and the registered result side.
interface myproject_mul_acc_pipe_if #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 22
);
    logic                  ce;
    logic                  in_valid;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  acc_en;
    logic                  acc_clr;
    logic                  out_valid;
    logic [dout_WIDTH-1:0] dout;
    logic                  ovf;

    modport master (
        output ce, in_valid, din0, din1, acc_en, acc_clr,
        input  out_valid, dout, ovf
    );

    modport slave (
        input  ce, in_valid, din0, din1, acc_en, acc_clr,
        output out_valid, dout, ovf
    );
endinterface

// File: rtl/myproject_mul_acc_pipe.sv
// Pipelined signed x unsigned multiplier with optional multiply-accumulate.
// Define MUL_ACC_SAT_EN to saturate the resize and the accumulate instead of wrapping.
module myproject_mul_acc_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 22
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    myproject_mul_acc_pipe_if.slave bus
);
    localparam int PW = din0_WIDTH + din1_WIDTH + 1;
    localparam int DW = dout_WIDTH;
    localparam int EW = (PW > DW) ? PW : DW;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] p_in;

    assign a_ext = PW'($signed(bus.din0));
    assign b_ext = PW'({1'b0, bus.din1});
    assign p_in  = a_ext * b_ext;

    logic signed [PW-1:0] fin_p;
    logic                 fin_v;
    logic                 fin_en;
    logic                 fin_clr;

    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign fin_p   = p_in;
            assign fin_v   = bus.in_valid;
            assign fin_en  = bus.acc_en;
            assign fin_clr = bus.acc_clr;
        end else begin : g_pipe
            localparam int NP = NUM_STAGE - 1;

            logic signed [PW-1:0] p_q [NP];
            logic signed [PW-1:0] p_d [NP];
            logic [NP-1:0]        v_q, v_d;
            logic [NP-1:0]        en_q, en_d;
            logic [NP-1:0]        clr_q, clr_d;

            always_comb begin
                p_d   = p_q;
                v_d   = v_q;
                en_d  = en_q;
                clr_d = clr_q;
                if (bus.ce) begin
                    p_d[0]   = p_in;
                    v_d[0]   = bus.in_valid;
                    en_d[0]  = bus.acc_en;
                    clr_d[0] = bus.acc_clr;
                    for (int i = 1; i < NP; i++) begin
                        p_d[i]   = p_q[i-1];
                        v_d[i]   = v_q[i-1];
                        en_d[i]  = en_q[i-1];
                        clr_d[i] = clr_q[i-1];
                    end
                end
            end

            // Only the valid bits need reset; stale data behind a cleared valid is never used.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) v_q <= '0;
                else        v_q <= v_d;
            end

            always_ff @(posedge ap_clk) begin
                p_q   <= p_d;
                en_q  <= en_d;
                clr_q <= clr_d;
            end

            assign fin_p   = p_q[NP-1];
            assign fin_v   = v_q[NP-1];
            assign fin_en  = en_q[NP-1];
            assign fin_clr = clr_q[NP-1];
        end
    endgenerate

    logic signed [DW-1:0] dout_q, dout_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic signed [EW-1:0] fin_ext;
    logic signed [DW-1:0] p_rs;
    logic signed [DW-1:0] sum_raw;
    logic signed [DW-1:0] acc_sum;
    logic                 add_ovf;

    assign fin_ext = EW'(fin_p);
    assign sum_raw = dout_q + p_rs;
    // Signed overflow: both addends share a sign and the sum's sign differs.
    assign add_ovf = (dout_q[DW-1] == p_rs[DW-1]) && (sum_raw[DW-1] != dout_q[DW-1]);

`ifdef MUL_ACC_SAT_EN
    localparam logic signed [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};

    always_comb begin
        p_rs = fin_ext[DW-1:0];
        if (fin_ext > EW'(D_MAX))      p_rs = D_MAX;
        else if (fin_ext < EW'(D_MIN)) p_rs = D_MIN;
    end

    assign acc_sum = add_ovf ? (dout_q[DW-1] ? D_MIN : D_MAX) : sum_raw;
`else
    assign p_rs    = fin_ext[DW-1:0];
    assign acc_sum = sum_raw;
`endif

    always_comb begin
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (bus.ce) begin
            out_valid_d = fin_v;
            if (fin_v) begin
                if (!fin_en) begin
                    dout_d = p_rs;
                end else if (fin_clr) begin
                    dout_d = p_rs;
                    ovf_d  = 1'b0;
                end else begin
                    dout_d = acc_sum;
                    ovf_d  = ovf_q | add_ovf;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dout_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;
endmodule
